// File: rtl/tts_pkg.sv
// Shared types and constants for the strategy lookup RAM blocks.
package tts_pkg;

  localparam int unsigned RCB_STAT_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DONE     = 2'd1,
    WAIT_REL = 2'd2
  } t_rcb_arb_state;

endpackage

// File: rtl/hpb_if.sv
// Host path block write channel into a RAM control block.
interface hpb_if #(
  parameter int unsigned HPB_ADDR_W = 32,
  parameter int unsigned HPB_DATA_W = 64,
  parameter int unsigned HPB_BE_W   = 8
);

  logic                  hpb_wr_req;
  logic [HPB_ADDR_W-1:0] hpb_wr_addr;
  logic [HPB_DATA_W-1:0] hpb_wr_data;
  logic [HPB_BE_W-1:0]   hpb_wr_byte_en;
  logic                  rcb_wr_done;

  modport arb (
    input  hpb_wr_req,
    input  hpb_wr_addr,
    input  hpb_wr_data,
    input  hpb_wr_byte_en,
    output rcb_wr_done
  );

  modport host (
    output hpb_wr_req,
    output hpb_wr_addr,
    output hpb_wr_data,
    output hpb_wr_byte_en,
    input  rcb_wr_done
  );

endinterface

// File: rtl/rcb_rd_pipe.sv
// Read-valid delay line matching the RAM read latency; synchronous active-low reset.
module rcb_rd_pipe #(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vld_in,
  output logic vld_out
);

  logic [RD_LATENCY-1:0] pipe_q, pipe_d;

  // Shift form keeps RD_LATENCY == 1 legal without a special case.
  always_comb begin
    pipe_d = (pipe_q << 1) | RD_LATENCY'(vld_in);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign vld_out = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/rcb_arb.sv
// Single-port lookup RAM arbiter: datapath reads win, host writes forced through by a starvation
// guard. Optional statistics counters are built when RCB_ARB_STATS_EN is defined.
module rcb_arb
  import tts_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned MAX_WR_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  hpb_if.arb                    hpb,
  output logic                  ram_en,
  output logic [BE_WIDTH-1:0]   ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [RCB_STAT_W-1:0] stat_wr_cnt,
  output logic [RCB_STAT_W-1:0] stat_rd_stall_cnt
);

  localparam int unsigned StarveW = (MAX_WR_WAIT > 0) ? $clog2(MAX_WR_WAIT + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(MAX_WR_WAIT);

  t_rcb_arb_state state_q, state_d;
  logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
  logic is_idle, starve_hit, rd_grant, wr_grant, wr_done;

  assign is_idle    = (state_q == IDLE);
  assign starve_hit = (starve_cnt_q == StarveMax);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (wr_grant) state_d = DONE;
      DONE:     state_d = WAIT_REL;
      WAIT_REL: if (!hpb.hpb_wr_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs and grants; rd_ready deliberately ignores rd_req.
  always_comb begin
    rd_ready  = !(is_idle && hpb.hpb_wr_req && starve_hit);
    rd_grant  = rd_req && rd_ready;
    wr_grant  = is_idle && hpb.hpb_wr_req && (!rd_req || starve_hit);
    wr_done   = (state_q == DONE);
    ram_en    = rd_grant || wr_grant;
    ram_we    = wr_grant ? hpb.hpb_wr_byte_en[BE_WIDTH-1:0] : '0;
    ram_addr  = wr_grant ? hpb.hpb_wr_addr[ADDR_WIDTH-1:0] : rd_addr;
    ram_wdata = hpb.hpb_wr_data[DATA_WIDTH-1:0];
  end

  // Count reads that beat a pending write; saturation stops at the forcing threshold.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!hpb.hpb_wr_req || wr_grant) begin
      starve_cnt_d = '0;
    end else if (is_idle && rd_grant && !starve_hit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  assign hpb.rcb_wr_done = wr_done;
  assign rd_data         = ram_rdata;

  rcb_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .vld_in  (rd_grant),
    .vld_out (rd_valid)
  );

`ifdef RCB_ARB_STATS_EN
  logic [RCB_STAT_W-1:0] stat_wr_cnt_q, stat_wr_cnt_d;
  logic [RCB_STAT_W-1:0] stat_rd_stall_cnt_q, stat_rd_stall_cnt_d;

  always_comb begin
    stat_wr_cnt_d       = stat_wr_cnt_q;
    stat_rd_stall_cnt_d = stat_rd_stall_cnt_q;
    if (wr_grant && (stat_wr_cnt_q != '1)) begin
      stat_wr_cnt_d = stat_wr_cnt_q + 1'b1;
    end
    if (rd_req && !rd_ready && (stat_rd_stall_cnt_q != '1)) begin
      stat_rd_stall_cnt_d = stat_rd_stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_wr_cnt_q       <= '0;
      stat_rd_stall_cnt_q <= '0;
    end else begin
      stat_wr_cnt_q       <= stat_wr_cnt_d;
      stat_rd_stall_cnt_q <= stat_rd_stall_cnt_d;
    end
  end

  assign stat_wr_cnt       = stat_wr_cnt_q;
  assign stat_rd_stall_cnt = stat_rd_stall_cnt_q;
`else
  assign stat_wr_cnt       = '0;
  assign stat_rd_stall_cnt = '0;
`endif

  // Host address/data may be wider than the RAM; upper bits are intentionally dropped.
  logic unused_hpb;
  assign unused_hpb = ^{hpb.hpb_wr_addr, hpb.hpb_wr_data, hpb.hpb_wr_byte_en};

endmodule

// File: tb/tb_rcb_arb.sv
// Directed bench for rcb_arb: default instance with a RAM model, plus a MAX_WR_WAIT=0 instance.
module tb_rcb_arb;

`ifdef RCB_ARB_STATS_EN
  localparam logic [63:0] ExpStat = 64'd1;
`else
  localparam logic [63:0] ExpStat = 64'd0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int a);
    return 64'hDA7A_0000_0000_0000 + 64'(a);
  endfunction

  // Default instance
  hpb_if hpb ();
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic        rd_ready, rd_valid;
  logic [63:0] rd_data;
  logic        ram_en;
  logic [7:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [63:0] ram_wdata, ram_rdata;
  logic [31:0] stat_wr_cnt, stat_rd_stall_cnt;

  rcb_arb u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_ready          (rd_ready),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .hpb               (hpb),
    .ram_en            (ram_en),
    .ram_we            (ram_we),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .ram_rdata         (ram_rdata),
    .stat_wr_cnt       (stat_wr_cnt),
    .stat_rd_stall_cnt (stat_rd_stall_cnt)
  );

  // Two-cycle byte-enabled RAM model
  logic [63:0] mem [1024];
  logic [63:0] rd_stage;
  int wr_seen = 0;
  always @(posedge clk) begin
    if (ram_en && ram_we == 8'h00) rd_stage <= mem[ram_addr];
    if (ram_en && ram_we != 8'h00) begin
      for (int b = 0; b < 8; b++) if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      wr_seen <= wr_seen + 1;
    end
    ram_rdata <= rd_stage;
  end

  // Strict-write-priority instance
  hpb_if hpb0 ();
  logic        rd_req0;
  logic [9:0]  rd_addr0;
  logic        rd_ready0, rd_valid0;
  logic [63:0] rd_data0;
  logic        ram_en0;
  logic [7:0]  ram_we0;
  logic [9:0]  ram_addr0;
  logic [63:0] ram_wdata0;
  logic [63:0] ram_rdata0 = 64'd0;
  logic [31:0] stat_wr_cnt0, stat_rd_stall_cnt0;

  rcb_arb #(
    .MAX_WR_WAIT (0)
  ) u_dut0 (
    .clk               (clk),
    .reset_n           (reset_n),
    .rd_req            (rd_req0),
    .rd_addr           (rd_addr0),
    .rd_ready          (rd_ready0),
    .rd_valid          (rd_valid0),
    .rd_data           (rd_data0),
    .hpb               (hpb0),
    .ram_en            (ram_en0),
    .ram_we            (ram_we0),
    .ram_addr          (ram_addr0),
    .ram_wdata         (ram_wdata0),
    .ram_rdata         (ram_rdata0),
    .stat_wr_cnt       (stat_wr_cnt0),
    .stat_rd_stall_cnt (stat_rd_stall_cnt0)
  );

  task automatic do_reset();
    reset_n = 1'b0;
    rd_req = 1'b0;
    hpb.hpb_wr_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic host_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    hpb.hpb_wr_req     = 1'b1;
    hpb.hpb_wr_addr    = a;
    hpb.hpb_wr_data    = d;
    hpb.hpb_wr_byte_en = be;
  endtask

  int wr_base;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);
    rd_stage = '0;
    ram_rdata = '0;
    rd_addr = '0;
    host_wr(32'h0, 64'h0, 8'h0);
    hpb.hpb_wr_req = 1'b0;
    rd_req0 = 1'b0;
    rd_addr0 = '0;
    hpb0.hpb_wr_req = 1'b0;
    hpb0.hpb_wr_addr = 32'h0;
    hpb0.hpb_wr_data = 64'h0;
    hpb0.hpb_wr_byte_en = 8'hFF;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_wr_done", 64'(hpb.rcb_wr_done), 64'd0);
    check_eq("rst_rd_ready", 64'(rd_ready), 64'd1);
    check_eq("rst_ram_en", 64'(ram_en), 64'd0);
    check_eq("rst_stat_wr", 64'(stat_wr_cnt), 64'd0);
    check_eq("rst_stat_stall", 64'(stat_rd_stall_cnt), 64'd0);
    check_eq("rst_rd_ready0", 64'(rd_ready0), 64'd1);

    // Read stream 0..15, data two cycles after each grant
    for (int i = 0; i < 18; i++) begin
      if (i > 0) tick();
      rd_req  = (i < 16);
      rd_addr = 10'(i);
      #1;
      if (i < 16) begin
        check_eq("stream_ram_en", 64'(ram_en), 64'd1);
        check_eq("stream_ram_addr", 64'(ram_addr), 64'(i));
        check_eq("stream_ram_we", 64'(ram_we), 64'd0);
      end
      if (i >= 2) begin
        check_eq("stream_rd_valid", 64'(rd_valid), 64'd1);
        check_eq("stream_rd_data", rd_data, pat(i - 2));
      end
    end
    tick();
    check_eq("stream_idle_valid", 64'(rd_valid), 64'd0);

    // Single write, request held three cycles past the done pulse
    host_wr(32'h3, 64'hABAB_ABAB_ABAB_ABAB, 8'hFF);
    wr_base = wr_seen;
    #1;
    check_eq("wr_ram_en", 64'(ram_en), 64'd1);
    check_eq("wr_ram_we", 64'(ram_we), 64'hFF);
    check_eq("wr_ram_addr", 64'(ram_addr), 64'h3);
    check_eq("wr_ram_wdata", ram_wdata, 64'hABAB_ABAB_ABAB_ABAB);
    tick();
    check_eq("wr_done_pulse", 64'(hpb.rcb_wr_done), 64'd1);
    check_eq("wr_done_no_en", 64'(ram_en), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wr_hold_done", 64'(hpb.rcb_wr_done), 64'd0);
      check_eq("wr_hold_no_en", 64'(ram_en), 64'd0);
    end
    hpb.hpb_wr_req = 1'b0;
    tick();
    check_eq("wr_single_count", 64'(wr_seen - wr_base), 64'd1);
    check_eq("wr_mem", mem[3], 64'hABAB_ABAB_ABAB_ABAB);

    // Read-after-write in the DONE cycle
    host_wr(32'h7, 64'h55, 8'hFF);
    tick();
    rd_req  = 1'b1;
    rd_addr = 10'd7;
    #1;
    check_eq("raw_done", 64'(hpb.rcb_wr_done), 64'd1);
    check_eq("raw_rd_ready", 64'(rd_ready), 64'd1);
    check_eq("raw_ram_en", 64'(ram_en), 64'd1);
    check_eq("raw_ram_we", 64'(ram_we), 64'd0);
    tick();
    rd_req = 1'b0;
    hpb.hpb_wr_req = 1'b0;
    tick();
    check_eq("raw_rd_valid", 64'(rd_valid), 64'd1);
    check_eq("raw_rd_data", rd_data, 64'h55);

    // Starvation guard: eight reads, one stall, write, reads resume
    tick();
    do_reset();
    rd_req = 1'b1;
    host_wr(32'h9, 64'h99, 8'h0F);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 10'(20 + i);
      #1;
      check_eq("starve_rd_ready", 64'(rd_ready), 64'd1);
      check_eq("starve_rd_we", 64'(ram_we), 64'd0);
      tick();
    end
    #1;
    check_eq("starve_stall", 64'(rd_ready), 64'd0);
    check_eq("starve_wr_en", 64'(ram_en), 64'd1);
    check_eq("starve_wr_we", 64'(ram_we), 64'h0F);
    check_eq("starve_wr_addr", 64'(ram_addr), 64'h9);
    tick();
    check_eq("starve_resume", 64'(rd_ready), 64'd1);
    check_eq("starve_resume_we", 64'(ram_we), 64'd0);
    check_eq("starve_done", 64'(hpb.rcb_wr_done), 64'd1);
    hpb.hpb_wr_req = 1'b0;
    tick();
    rd_req = 1'b0;
    #1;
    check_eq("stat_rd_stall", 64'(stat_rd_stall_cnt), ExpStat);
    check_eq("stat_wr", 64'(stat_wr_cnt), ExpStat);

    // Reset right after a read grant and a write grant
    tick();
    tick();
    rd_req  = 1'b1;
    rd_addr = 10'd1;
    tick();
    rd_req = 1'b0;
    host_wr(32'hC, 64'h12, 8'hFF);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("rstmid_rd_valid", 64'(rd_valid), 64'd0);
    check_eq("rstmid_done", 64'(hpb.rcb_wr_done), 64'd0);
    check_eq("rstmid_reissue_we", 64'(ram_we), 64'hFF);
    check_eq("rstmid_reissue_addr", 64'(ram_addr), 64'hC);
    tick();
    check_eq("rstmid_done_after", 64'(hpb.rcb_wr_done), 64'd1);
    check_eq("rstmid_rd_valid2", 64'(rd_valid), 64'd0);
    hpb.hpb_wr_req = 1'b0;

    // MAX_WR_WAIT = 0: write wins at once, next write three cycles later
    tick();
    rd_req0 = 1'b1;
    hpb0.hpb_wr_req = 1'b1;
    #1;
    check_eq("prio_rd_ready", 64'(rd_ready0), 64'd0);
    check_eq("prio_wr_we", 64'(ram_we0), 64'hFF);
    tick();
    check_eq("prio_done", 64'(hpb0.rcb_wr_done), 64'd1);
    check_eq("prio_done_rd", 64'(rd_ready0), 64'd1);
    tick();
    hpb0.hpb_wr_req = 1'b0;
    #1;
    check_eq("prio_wait_rel_we", 64'(ram_we0), 64'd0);
    check_eq("prio_wait_rel_rd", 64'(ram_en0), 64'd1);
    tick();
    hpb0.hpb_wr_req = 1'b1;
    #1;
    check_eq("prio_second_we", 64'(ram_we0), 64'hFF);
    check_eq("prio_second_rd", 64'(rd_ready0), 64'd0);
    tick();
    check_eq("prio_second_done", 64'(hpb0.rcb_wr_done), 64'd1);
    hpb0.hpb_wr_req = 1'b0;
    rd_req0 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
